// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int PC_STEP      = 4;
    localparam int WAIT_W       = 8;

    // Wide enough for any XLEN up to 64; callers truncate to their own width.
    localparam logic [63:0] ALIGN_MASK = ~64'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - consecutive no-ack cycle counter with sticky hang flag
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic fetch_timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;

    // Saturate so a long hang cannot wrap the count back below the limit.
    assign wait_inc = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + WAIT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else if (clear || !waiting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == LIMIT) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner, imem req/ack sequencer and decode buffer
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_ret_addr,
    output logic            fetch_timeout
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] MASK = XLEN'(ALIGN_MASK);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, addr_d, if_pc_d, ret_d;
    logic [31:0]     instr_d;
    logic            req_d, valid_d;
    logic            busy, redirect, fetch_done;

    assign busy       = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign redirect   = redirect_valid && (state_q != ST_IDLE);
    assign fetch_done = (state_q == ST_REQ) && imem_ack && !redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request already on the bus is never withdrawn; a redirect turns it into a drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (!redirect_valid && imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || if_ready) begin
                    state_d = ST_REQ;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        addr_d  = imem_addr;
        valid_d = if_valid;
        instr_d = if_instr;
        if_pc_d = if_pc;
        ret_d   = if_ret_addr;

        if (redirect) begin
            pc_d = redirect_target & MASK;
        end else if (fetch_done) begin
            pc_d = pc_q + STEP;
        end

        if (fetch_done) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            if_pc_d = pc_q;
            ret_d   = pc_q + STEP;
        end else if (redirect || ((state_q == ST_HOLD) && if_ready)) begin
            valid_d = 1'b0;
        end

        req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        if (state_d == ST_REQ) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_ret_addr <= '0;
        end else begin
            pc_q        <= pc_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            if_valid    <= valid_d;
            if_instr    <= instr_d;
            if_pc       <= if_pc_d;
            if_ret_addr <= ret_d;
        end
    end

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk           (clk),
        .reset         (reset),
        .waiting       (busy && !imem_ack),
        .clear         (redirect),
        .fetch_timeout (fetch_timeout)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench with a transaction-level fetch model
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
    localparam int          MAXW   = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_ret_addr;
    logic        fetch_timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] acked[$];

    fetch_sequencer #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ret_addr     (if_ret_addr),
        .fetch_timeout   (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding read (possibly stale), a one-entry decode buffer, a next-PC.
    logic        m_started = 1'b0, m_req = 1'b0, m_stale = 1'b0, m_valid = 1'b0, m_to = 1'b0;
    logic [31:0] m_addr = '0, m_next = RST_PC, m_instr = '0, m_pc = '0, m_ret = '0;
    int          m_wait = 0;
    logic        m_done, m_had;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started = 1'b0; m_req = 1'b0; m_stale = 1'b0; m_valid = 1'b0; m_to = 1'b0;
            m_addr = '0; m_next = RST_PC; m_instr = '0; m_pc = '0; m_ret = '0; m_wait = 0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = m_next;
        end else begin
            m_done = m_req && imem_ack;
            m_had  = m_valid;
            if (m_req && !imem_ack && !redirect_valid) begin
                if (m_wait < MAXW) m_wait++;
                if (m_wait == MAXW) m_to = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (m_had && (if_ready || redirect_valid)) m_valid = 1'b0;
            if (m_done && !m_stale && !redirect_valid) begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
                m_pc    = m_addr;
                m_ret   = m_addr + 32'd4;
                m_next  = m_addr + 32'd4;
            end
            if (redirect_valid) m_next = redirect_target & ~32'd3;
            if (m_req) begin
                if (!m_done) begin
                    m_stale = m_stale || redirect_valid;
                end else if (m_stale && redirect_valid) begin
                    m_stale = 1'b1;
                end else if (m_stale || redirect_valid) begin
                    m_addr  = m_next;
                    m_stale = 1'b0;
                end else begin
                    m_req = 1'b0;
                end
            end else if (m_had && (if_ready || redirect_valid)) begin
                m_req  = 1'b1;
                m_addr = m_next;
            end
        end
    end

    always @(negedge clk) begin
        check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("fetch_timeout", {31'd0, fetch_timeout}, {31'd0, m_to});
        if (m_req) check("imem_addr", imem_addr, m_addr);
        if (m_valid) begin
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_pc);
            check("if_ret_addr", if_ret_addr, m_ret);
        end
    end

    task automatic drive(input logic rd, input logic [31:0] tgt, input logic ack_en, input logic rdy);
        redirect_valid  = rd;
        redirect_target = tgt;
        if_ready        = rdy;
        imem_ack        = ack_en && imem_req;
        imem_rdata      = $urandom;
        if (imem_ack) acked.push_back(imem_addr);
        @(negedge clk);
    endtask

    initial begin
        int stall;
        logic ack_en, rd, rdy;
        logic [31:0] tgt;

        repeat (3) @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b1);
            if (i == 7) begin
                check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
                check("wrap_ret_addr", if_ret_addr, 32'h0000_0000);
            end
            if (i == 8) check("wrap_next_addr", imem_addr, 32'h0000_0000);
        end
        check("ack_count", acked.size(), 32'd5);
        if (acked.size() >= 5) begin
            check("ack_addr0", acked[0], 32'hFFFF_FFF0);
            check("ack_addr1", acked[1], 32'hFFFF_FFF4);
            check("ack_addr2", acked[2], 32'hFFFF_FFF8);
            check("ack_addr3", acked[3], 32'hFFFF_FFFC);
            check("ack_addr4", acked[4], 32'h0000_0000);
        end

        repeat (5) drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("hold_no_req", {31'd0, imem_req}, 32'd0);
        check("hold_valid", {31'd0, if_valid}, 32'd1);
        check("hold_pc", if_pc, 32'd0);
        check("hold_ack_count", acked.size(), 32'd5);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        check("after_hs_addr", imem_addr, 32'd4);
        check("after_hs_valid", {31'd0, if_valid}, 32'd0);

        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h103, 1'b0, 1'b0);
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_old_addr", imem_addr, 32'd4);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain_dropped", {31'd0, if_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("redir_pc", if_pc, 32'h100);
        check("redir_ret", if_ret_addr, 32'h104);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        check("same_cyc_valid", {31'd0, if_valid}, 32'd0);
        check("same_cyc_addr", imem_addr, 32'h200);
        check("same_cyc_req", {31'd0, imem_req}, 32'd1);

        repeat (MAXW - 1) drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("timeout_early", {31'd0, fetch_timeout}, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("timeout_set", {31'd0, fetch_timeout}, 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);
        check("late_ack_pc", if_pc, 32'h200);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'd0);
        check("async_valid", {31'd0, if_valid}, 32'd0);
        check("async_instr", if_instr, 32'd0);
        check("async_pc", if_pc, 32'd0);
        check("async_ret", if_ret_addr, 32'd0);
        check("async_timeout", {31'd0, fetch_timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        check("restart_addr", acked[acked.size()-1], RST_PC);

        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) stall = $urandom_range(5, 20);
            ack_en = (stall > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (stall > 0) stall--;
            rd  = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                drive(rd, tgt, ack_en, rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
